// File: rtl/_7z_wayz_rr_grant_pkg.sv
// Shared arbiter definitions: channel count, index width, FSM state encoding.
// Imported by the rr_pick7 scanner, the grant interface and the arbiter top.
package overture_arb_pkg;

    localparam int unsigned CHANNELS = 7;
    localparam int unsigned IDX_W    = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Channel number 1..CHANNELS to one-hot vector; 0 maps to no bit set.
    function automatic logic [CHANNELS-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [CHANNELS-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (idx == IDX_W'(i + 1)) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/_7z_wayz_rr_grant_if.sv
// Request/grant bundle for the seven-way round-robin arbiter.
// master drives requests and Ack; slave returns grants and status.
interface _7z_wayz_rr_grant_if;
    import overture_arb_pkg::*;

    logic [CHANNELS-1:0] req;
    logic                ack;
    logic [CHANNELS-1:0] grant;
    logic [IDX_W-1:0]    index;
    logic                busy;
    logic                timeout;

    modport master (
        output req, ack,
        input  grant, index, busy, timeout
    );

    modport slave (
        input  req, ack,
        output grant, index, busy, timeout
    );

endinterface

// File: rtl/_7z_wayz_rr_grant_rr_pick7.sv
// Combinational wrap-around scan: first requesting channel after ptr,
// visiting ptr+1 .. 7 then 1 .. ptr. Index is 1-based, 0 when nothing found.
module rr_pick7
    import overture_arb_pkg::*;
#(
    parameter int UUID = 0
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [IDX_W-1:0]    ptr,
    output logic                found,
    output logic [IDX_W-1:0]    idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        // Bit position of channel ptr+off is (ptr+off-1) mod 7; ptr=7 wraps to channel 1.
        for (int unsigned off = 1; off <= CHANNELS; off++) begin
            if (!found && req[IDX_W'((32'(ptr) + off - 1) % CHANNELS)]) begin
                found = 1'b1;
                idx   = IDX_W'((32'(ptr) + off - 1) % CHANNELS + 1);
            end
        end
    end

endmodule

// File: rtl/_7z_wayz_rr_grant.sv
// Seven-way round-robin grant arbiter with registered one-hot grants.
// Optional grant-hold timeout compiled in with OVERTURE_GRANT_TIMEOUT_EN.
module _7z_wayz_rr_grant
    import overture_arb_pkg::*;
#(
    parameter int          UUID    = 0,
    parameter              NAME    = "",
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Request_1,
    input  logic             Request_2,
    input  logic             Request_3,
    input  logic             Request_4,
    input  logic             Request_5,
    input  logic             Request_6,
    input  logic             Request_7,
    input  logic             Ack,
    output logic             Grant_1,
    output logic             Grant_2,
    output logic             Grant_3,
    output logic             Grant_4,
    output logic             Grant_5,
    output logic             Grant_6,
    output logic             Grant_7,
    output logic [IDX_W-1:0] Index,
    output logic             Busy,
    output logic             Timeout
);

    logic [CHANNELS-1:0] req_v;
    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;
    logic                tmo_hit;
    logic                release_c;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CHANNELS-1:0] grant_q, grant_d;
    logic                busy_q, busy_d;

    assign req_v = {Request_7, Request_6, Request_5, Request_4,
                    Request_3, Request_2, Request_1};

    rr_pick7 #(
        .UUID (UUID ^ 1)
    ) u_pick (
        .req   (req_v),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // grant_q is one-hot on the served channel, so masking gives its request level.
    assign release_c = (state_q == GRANT) &&
                       (Ack || !(|(req_v & grant_q)) || tmo_hit);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    idx_d   = pick_idx;
                    grant_d = idx_onehot(pick_idx);
                    busy_d  = 1'b1;
                end
            end
            GRANT: begin
                if (release_c) begin
                    state_d = IDLE;
                    ptr_d   = idx_q;
                    idx_d   = '0;
                    grant_d = '0;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= IDX_W'(CHANNELS);
            idx_q   <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
        end
    end

`ifdef OVERTURE_GRANT_TIMEOUT_EN
    generate
        if (TIMEOUT != 0) begin : g_tmo
            logic [7:0] cnt_q, cnt_d;
            logic       tmo_q, tmo_d;

            // Counter value k-1 during the k-th GRANT cycle; expiry is on the TIMEOUT-th.
            assign tmo_hit = (state_q == GRANT) && (cnt_q == 8'(TIMEOUT - 1));

            always_comb begin
                cnt_d = cnt_q;
                tmo_d = 1'b0;
                if (state_q == IDLE) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    tmo_d = tmo_hit;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_q <= '0;
                    tmo_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    tmo_q <= tmo_d;
                end
            end

            assign Timeout = tmo_q;
        end else begin : g_no_tmo
            assign tmo_hit = 1'b0;
            assign Timeout = 1'b0;
        end
    endgenerate
`else
    assign tmo_hit = 1'b0;
    assign Timeout = 1'b0;
`endif

    assign Grant_1 = grant_q[0];
    assign Grant_2 = grant_q[1];
    assign Grant_3 = grant_q[2];
    assign Grant_4 = grant_q[3];
    assign Grant_5 = grant_q[4];
    assign Grant_6 = grant_q[5];
    assign Grant_7 = grant_q[6];
    assign Index   = idx_q;
    assign Busy    = busy_q;

endmodule

// File: tb/tb__7z_wayz_rr_grant.sv
// Directed bench for the seven-way round-robin arbiter; timeout scenario
// is selected by OVERTURE_GRANT_TIMEOUT_EN to match the build under test.
module tb__7z_wayz_rr_grant;

    logic clk;
    logic rst;
    int unsigned chk_cnt;
    int unsigned err_cnt;

    _7z_wayz_rr_grant_if bus ();

    _7z_wayz_rr_grant #(
        .UUID    (0),
        .NAME    ("tb_arb"),
        .TIMEOUT (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .Request_1 (bus.req[0]),
        .Request_2 (bus.req[1]),
        .Request_3 (bus.req[2]),
        .Request_4 (bus.req[3]),
        .Request_5 (bus.req[4]),
        .Request_6 (bus.req[5]),
        .Request_7 (bus.req[6]),
        .Ack       (bus.ack),
        .Grant_1   (bus.grant[0]),
        .Grant_2   (bus.grant[1]),
        .Grant_3   (bus.grant[2]),
        .Grant_4   (bus.grant[3]),
        .Grant_5   (bus.grant[4]),
        .Grant_6   (bus.grant[5]),
        .Grant_7   (bus.grant[6]),
        .Index     (bus.index),
        .Busy      (bus.busy),
        .Timeout   (bus.timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed observation: {Grant_7..Grant_1, Index, Busy, Timeout}.
    function automatic logic [11:0] exp_out(input int unsigned k, input logic t);
        logic [6:0] g;
        g = '0;
        if (k != 0) g = 7'(1 << (k - 1));
        return {g, 3'(k), (k != 0), t};
    endfunction

    function automatic logic [11:0] obs();
        return {bus.grant, bus.index, bus.busy, bus.timeout};
    endfunction

    task automatic check(input string tag, input logic [11:0] act, input logic [11:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %03h expected %03h ({grant,index,busy,timeout})", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Asserts reset between edges, checks the asynchronous clear, releases after one edge.
    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        check(tag, obs(), exp_out(0, 1'b0));
        step();
        check({tag, "_held"}, obs(), exp_out(0, 1'b0));
        rst = 1'b1;
    endtask

    initial begin
        int unsigned order [8] = '{1, 2, 3, 4, 5, 6, 7, 1};
        chk_cnt = 0;
        err_cnt = 0;
        rst     = 1'b1;
        bus.req = '0;
        bus.ack = 1'b0;
        #2;
        do_reset("reset");
        step();
        check("idle_after_reset", obs(), exp_out(0, 1'b0));

        // Single request, Ack release, then pointer placement proven via 2 vs 4.
        bus.req = 7'b0000100;
        step();
        check("grant3", obs(), exp_out(3, 1'b0));
        bus.ack = 1'b1;
        bus.req = 7'b0000000;
        step();
        check("release3", obs(), exp_out(0, 1'b0));
        bus.ack = 1'b0;
        bus.req = 7'b0001010;
        step();
        check("ptr3_picks4", obs(), exp_out(4, 1'b0));
        bus.ack = 1'b1;
        bus.req = 7'b0000010;
        step();
        check("release4", obs(), exp_out(0, 1'b0));
        bus.ack = 1'b0;
        step();
        check("wrap_to2", obs(), exp_out(2, 1'b0));
        bus.req = 7'b0000000;
        step();
        check("drop_release2", obs(), exp_out(0, 1'b0));

        // All seven requesting: strict rotation with one idle cycle per hand-over.
        do_reset("reset2");
        bus.req = 7'b1111111;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("rr_grant_%0d", i), obs(), exp_out(order[i], 1'b0));
            if (i == 0) begin
                step();
                check("rr_hold", obs(), exp_out(order[i], 1'b0));
            end
            bus.ack = 1'b1;
            step();
            check($sformatf("rr_idle_%0d", i), obs(), exp_out(0, 1'b0));
            bus.ack = 1'b0;
        end

        // Request drop and Ack together is one release; pointer moves to 5.
        bus.req = 7'b0010000;
        step();
        check("grant5", obs(), exp_out(5, 1'b0));
        bus.req = 7'b0100000;
        bus.ack = 1'b1;
        step();
        check("release5_dual", obs(), exp_out(0, 1'b0));
        bus.ack = 1'b0;
        step();
        check("grant6_after5", obs(), exp_out(6, 1'b0));
        bus.ack = 1'b1;
        bus.req = 7'b0000000;
        step();
        check("release6", obs(), exp_out(0, 1'b0));
        step();
        check("idle_ack_ignored", obs(), exp_out(0, 1'b0));
        bus.ack = 1'b0;

        // Lone requester is re-granted after its own release.
        bus.req = 7'b0000001;
        step();
        check("solo_grant1", obs(), exp_out(1, 1'b0));
        bus.ack = 1'b1;
        step();
        check("solo_release1", obs(), exp_out(0, 1'b0));
        bus.ack = 1'b0;
        step();
        check("solo_regrant1", obs(), exp_out(1, 1'b0));
        bus.req = 7'b0000000;
        step();
        check("solo_drop1", obs(), exp_out(0, 1'b0));

        do_reset("reset3");
        bus.req = 7'b0000010;
`ifdef OVERTURE_GRANT_TIMEOUT_EN
        for (int c = 1; c <= 4; c++) begin
            step();
            check($sformatf("tmo_hold_%0d", c), obs(), exp_out(2, 1'b0));
        end
        step();
        check("tmo_pulse", obs(), exp_out(0, 1'b1));
        step();
        check("tmo_regrant", obs(), exp_out(2, 1'b0));
        step();
        step();
        step();
        check("tmo_hold4_again", obs(), exp_out(2, 1'b0));
        bus.ack = 1'b1;
        step();
        check("tmo_with_ack", obs(), exp_out(0, 1'b1));
        bus.ack = 1'b0;
        bus.req = 7'b0000000;
        step();
        check("tmo_pulse_end", obs(), exp_out(0, 1'b0));
`else
        for (int c = 1; c <= 20; c++) begin
            step();
            if (c % 5 == 0) check($sformatf("no_tmo_hold_%0d", c), obs(), exp_out(2, 1'b0));
        end
        bus.ack = 1'b1;
        bus.req = 7'b0000000;
        step();
        check("no_tmo_release", obs(), exp_out(0, 1'b0));
        bus.ack = 1'b0;
`endif

        // Reset during a grant drops it at once and restores channel-1 priority.
        do_reset("reset4");
        bus.req = 7'b0100000;
        step();
        check("grant6", obs(), exp_out(6, 1'b0));
        rst = 1'b0;
        #1;
        check("rst_mid_grant", obs(), exp_out(0, 1'b0));
        bus.req = 7'b0100001;
        step();
        check("rst_mid_held", obs(), exp_out(0, 1'b0));
        rst = 1'b1;
        step();
        check("post_rst_grant1", obs(), exp_out(1, 1'b0));

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/_7z_wayz_rr_grant.md
_7Z_WAYZ_RR_GRANT -- requirements
Module: _7z_wayz_rr_grant

Interface
REQ-001 SHALL have parameter UUID, default 0, component identifier XOR-ed into child instance UUIDs.
REQ-002 SHALL have parameter NAME, default "", display name, no functional effect.
REQ-003 SHALL have parameter TIMEOUT, default 16, 8-bit grant-hold limit in cycles; 0 = no limit.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports Request_1..Request_7  input  1 each  per-channel request, level-held until served.
REQ-007 SHALL have port Ack  input  1  shared resource done, sampled only while granting.
REQ-008 SHALL have ports Grant_1..Grant_7  output  1 each  registered grant, at most one high.
REQ-009 SHALL have port Index  output  3  granted channel number 1..7, 0 when none.
REQ-010 SHALL have port Busy  output  1  high while any Grant is high.
REQ-011 SHALL have port Timeout  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-012 SHALL implement FSM states IDLE and GRANT; reset state IDLE.
REQ-013 SHALL hold a 3-bit round-robin pointer ptr (last served channel, 1..7).
REQ-014 In IDLE with any Request high, SHALL select first requesting channel scanning ptr+1, ptr+2, ... wrapping 7->1, and enter GRANT; Grant_k, Index=k, Busy=1 visible the next cycle (1-cycle latency).
REQ-015 In IDLE with no request, SHALL remain IDLE, all Grant/Index/Busy 0; Ack ignored.
REQ-016 In GRANT, SHALL hold the grant unchanged while Ack=0 and Request_k=1.
REQ-017 In GRANT, Ack=1 or Request_k=0 (either or both in same cycle) SHALL release: next cycle Grants, Index, Busy 0, ptr:=k, state IDLE.
REQ-018 SHALL insert exactly one IDLE cycle between consecutive grants; no back-to-back grant.
REQ-019 Requests of other channels during GRANT SHALL not affect the current grant.
REQ-020 A channel requesting alone SHALL be re-granted after each release (pointer wrap to itself).

Reset
REQ-021 On rst=0, asynchronously: state IDLE, ptr=7 (channel 1 first priority), Grant_1..7=0, Index=0, Busy=0, Timeout=0, hold counter=0.
REQ-022 Reset asserted mid-GRANT SHALL drop the grant immediately without updating ptr beyond reset value.

Configuration
REQ-023 Macro OVERTURE_GRANT_TIMEOUT_EN SHALL compile in an 8-bit hold counter.
REQ-024 With macro and TIMEOUT>0: counter clears on grant entry, increments each GRANT cycle; when it reaches TIMEOUT without release, SHALL release as REQ-017 and pulse Timeout for the release cycle; Ack in that same cycle still counts as one release, Timeout still pulses.
REQ-025 Without macro (or TIMEOUT=0): no counter logic, Timeout tied 0, grants held indefinitely; port list identical.

Structure
REQ-026 Shared package overture_arb_pkg SHALL hold CHANNELS=7, IDX_W=3, state enum (IDLE, GRANT).
REQ-027 Sub-module rr_pick7 (combinational: 7-bit request vector + ptr -> found flag + 3-bit index) SHALL implement the wrap-around scan.

Verification
REQ-028 Reset, Request_3=1 -> cycle+1 Grant_3=1, Index=3, Busy=1; Ack pulse -> cycle+1 all 0, ptr=3.
REQ-029 All seven requests held, Ack each grant -> grant order 1,2,3,4,5,6,7,1 with one idle cycle between.
REQ-030 Request_5 granted, Request_5 drops with Ack=1 same cycle -> single release, ptr=5, next grant to 6 if requested.
REQ-031 Macro on, TIMEOUT=4, Request_2 held, no Ack -> Grant_2 high 4 cycles, Timeout pulse 1 cycle, then regranted after one idle cycle.
REQ-032 rst low while Grant_6 high -> Grant_6/Busy/Index 0 immediately; after release, Request_6 and Request_1 both high -> Grant_1 first.
